// File: rtl/mdu_pkg.sv
// mdu_pkg: op codes, FSM state type and hazard helper shared by the
// multiply/divide unit and the decode/hazard stage.
// Optional feature macro: MDU_MADD_EN (op 6 = MADD, op 7 = MSUB).
package mdu_pkg;

  localparam logic [2:0] MDU_MULT  = 3'd0;
  localparam logic [2:0] MDU_MULTU = 3'd1;
  localparam logic [2:0] MDU_DIV   = 3'd2;
  localparam logic [2:0] MDU_DIVU  = 3'd3;
  localparam logic [2:0] MDU_MTHI  = 3'd4;
  localparam logic [2:0] MDU_MTLO  = 3'd5;
  localparam logic [2:0] MDU_MADD  = 3'd6;
  localparam logic [2:0] MDU_MSUB  = 3'd7;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mdu_state_e;

  // True for op codes that occupy the unit for several cycles.
  function automatic logic is_mdu_long(input logic [2:0] op);
    logic long_s;
    case (op)
      MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: long_s = 1'b1;
`ifdef MDU_MADD_EN
      MDU_MADD, MDU_MSUB: long_s = 1'b1;
`endif
      default: long_s = 1'b0;
    endcase
    return long_s;
  endfunction

endpackage

// File: rtl/mdu_divider.sv
// mdu_divider: combinational signed/unsigned quotient and remainder.
// Quotient truncates toward zero, remainder takes the dividend's sign.
// MIN / -1 yields quotient MIN, remainder 0. A zero divisor is flagged
// so the caller can leave its result registers untouched.
module mdu_divider #(
  parameter int WIDTH = 32
) (
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam logic [WIDTH-1:0] ONE_VAL  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ZERO_VAL = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES_VAL = {WIDTH{1'b1}};

  logic             neg_dvd_s;
  logic             neg_dvs_s;
  logic             overflow_s;
  logic [WIDTH-1:0] mag_dvd_s;
  logic [WIDTH-1:0] mag_dvs_s;
  logic [WIDTH-1:0] q_mag_s;
  logic [WIDTH-1:0] r_mag_s;

  // Divide magnitudes, then restore signs; overflow and zero cases override.
  always_comb begin
    neg_dvd_s  = is_signed & dividend[WIDTH-1];
    neg_dvs_s  = is_signed & divisor[WIDTH-1];
    div_zero   = (divisor == ZERO_VAL);
    overflow_s = is_signed && (dividend == MIN_VAL) && (divisor == ONES_VAL);

    if (neg_dvd_s) begin
      mag_dvd_s = ~dividend + ONE_VAL;
    end else begin
      mag_dvd_s = dividend;
    end

    if (neg_dvs_s) begin
      mag_dvs_s = ~divisor + ONE_VAL;
    end else begin
      mag_dvs_s = divisor;
    end

    if (div_zero) begin
      q_mag_s = ZERO_VAL;
      r_mag_s = ZERO_VAL;
    end else begin
      q_mag_s = mag_dvd_s / mag_dvs_s;
      r_mag_s = mag_dvd_s % mag_dvs_s;
    end

    if (overflow_s) begin
      quotient  = MIN_VAL;
      remainder = ZERO_VAL;
    end else begin
      if (neg_dvd_s ^ neg_dvs_s) begin
        quotient = ~q_mag_s + ONE_VAL;
      end else begin
        quotient = q_mag_s;
      end
      if (neg_dvd_s) begin
        remainder = ~r_mag_s + ONE_VAL;
      end else begin
        remainder = r_mag_s;
      end
    end
  end

endmodule

// File: rtl/mdu_pipe_chk.sv
// mdu_pipe_chk: protocol checker for mdu_pipe. The hazard stage must hold
// MDU-class instructions on stall, so a start while busy is a violation.
// 'en' lets a harness mask deliberate violations.
module mdu_pipe_chk (
  input logic clk,
  input logic reset,
  input logic en,
  input logic start,
  input logic busy
);

  property p_no_start_while_busy;
    @(posedge clk) disable iff (reset) (en && busy) |-> !start;
  endproperty

  a_no_start_while_busy: assert property (p_no_start_while_busy);

endmodule

// File: rtl/mdu_pipe.sv
// mdu_pipe: multiply/divide unit with HI/LO registers beside the EX ALU.
// A long op computes its full result at issue into a pending register,
// then counts down its latency and commits to HI/LO on the final edge.
// Optional feature macro: MDU_MADD_EN (signed MADD/MSUB accumulate into HI/LO).
module mdu_pipe
  import mdu_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             cancel,
  output logic             busy,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MULT = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_DIV  = CNT_W'(DIV_CYCLES);

  mdu_state_e         state_r;
  mdu_state_e         state_next_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [CNT_W-1:0]   cnt_next_s;
  logic               busy_r;
  logic               busy_next_s;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   hi_next_s;
  logic [WIDTH-1:0]   lo_r;
  logic [WIDTH-1:0]   lo_next_s;
  logic [2*WIDTH-1:0] pend_r;
  logic [2*WIDTH-1:0] pend_next_s;
  logic [2:0]         op_r;
  logic [2:0]         op_next_s;
  logic               div_zero_r;
  logic               div_zero_next_s;

  logic [2*WIDTH-1:0] prod_signed_s;
  logic [2*WIDTH-1:0] prod_unsigned_s;
  logic [WIDTH-1:0]   quot_s;
  logic [WIDTH-1:0]   rem_s;
  logic               div_zero_s;

  // Full-width products of the forwarded operands.
  assign prod_signed_s = $signed({{WIDTH{rs_data[WIDTH-1]}}, rs_data})
                       * $signed({{WIDTH{rt_data[WIDTH-1]}}, rt_data});
  assign prod_unsigned_s = {{WIDTH{1'b0}}, rs_data} * {{WIDTH{1'b0}}, rt_data};

  // DIV is op 2 and DIVU op 3, so bit 0 clear selects signed division.
  mdu_divider #(
    .WIDTH(WIDTH)
  ) u_divider (
    .is_signed (~op[0]),
    .dividend  (rs_data),
    .divisor   (rt_data),
    .quotient  (quot_s),
    .remainder (rem_s),
    .div_zero  (div_zero_s)
  );

  assign busy  = busy_r;
  assign hi    = hi_r;
  assign lo    = lo_r;
  assign stall = (start & ~cancel & is_mdu_long(op)) | busy_r;

  // Next-state logic: issue decode in IDLE, countdown/commit/abort in RUN.
  always_comb begin
    state_next_s    = state_r;
    cnt_next_s      = cnt_r;
    busy_next_s     = busy_r;
    hi_next_s       = hi_r;
    lo_next_s       = lo_r;
    pend_next_s     = pend_r;
    op_next_s       = op_r;
    div_zero_next_s = div_zero_r;

    case (state_r)
      IDLE: begin
        if (start && !cancel) begin
          case (op)
            MDU_MULT: begin
              pend_next_s  = prod_signed_s;
              cnt_next_s   = CNT_MULT;
              op_next_s    = op;
              busy_next_s  = 1'b1;
              state_next_s = RUN;
            end
            MDU_MULTU: begin
              pend_next_s  = prod_unsigned_s;
              cnt_next_s   = CNT_MULT;
              op_next_s    = op;
              busy_next_s  = 1'b1;
              state_next_s = RUN;
            end
            MDU_DIV, MDU_DIVU: begin
              pend_next_s     = {rem_s, quot_s};
              div_zero_next_s = div_zero_s;
              cnt_next_s      = CNT_DIV;
              op_next_s       = op;
              busy_next_s     = 1'b1;
              state_next_s    = RUN;
            end
            MDU_MTHI: begin
              hi_next_s = rs_data;
            end
            MDU_MTLO: begin
              lo_next_s = rs_data;
            end
`ifdef MDU_MADD_EN
            MDU_MADD, MDU_MSUB: begin
              pend_next_s  = prod_signed_s;
              cnt_next_s   = CNT_MULT;
              op_next_s    = op;
              busy_next_s  = 1'b1;
              state_next_s = RUN;
            end
`endif
            default: begin
              state_next_s = IDLE;
            end
          endcase
        end else begin
          state_next_s = IDLE;
        end
      end

      RUN: begin
        if (cancel) begin
          state_next_s = IDLE;
          busy_next_s  = 1'b0;
          cnt_next_s   = CNT_ZERO;
        end else if (cnt_r == CNT_ONE) begin
          state_next_s = IDLE;
          busy_next_s  = 1'b0;
          cnt_next_s   = CNT_ZERO;
          case (op_r)
            MDU_MULT, MDU_MULTU: begin
              {hi_next_s, lo_next_s} = pend_r;
            end
            MDU_DIV, MDU_DIVU: begin
              if (div_zero_r) begin
                hi_next_s = hi_r;
                lo_next_s = lo_r;
              end else begin
                {hi_next_s, lo_next_s} = pend_r;
              end
            end
`ifdef MDU_MADD_EN
            MDU_MADD: begin
              {hi_next_s, lo_next_s} = {hi_r, lo_r} + pend_r;
            end
            MDU_MSUB: begin
              {hi_next_s, lo_next_s} = {hi_r, lo_r} - pend_r;
            end
`endif
            default: begin
              hi_next_s = hi_r;
              lo_next_s = lo_r;
            end
          endcase
        end else begin
          cnt_next_s = cnt_r - CNT_ONE;
        end
      end

      default: begin
        state_next_s = IDLE;
        busy_next_s  = 1'b0;
        cnt_next_s   = CNT_ZERO;
      end
    endcase
  end

  // State and result registers; reset drops any in-flight op and clears HI/LO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      cnt_r      <= CNT_ZERO;
      busy_r     <= 1'b0;
      hi_r       <= {WIDTH{1'b0}};
      lo_r       <= {WIDTH{1'b0}};
      pend_r     <= {(2*WIDTH){1'b0}};
      op_r       <= 3'd0;
      div_zero_r <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      cnt_r      <= cnt_next_s;
      busy_r     <= busy_next_s;
      hi_r       <= hi_next_s;
      lo_r       <= lo_next_s;
      pend_r     <= pend_next_s;
      op_r       <= op_next_s;
      div_zero_r <= div_zero_next_s;
    end
  end

endmodule

// File: tb/tb_mdu_pipe.sv
// tb_mdu_pipe: scoreboard bench for mdu_pipe. The driver predicts HI/LO
// from plain arithmetic and queues the expectation; the monitor pops and
// compares whenever the unit finishes an op (busy falls) or HI/LO change
// while idle.
module tb_mdu_pipe;

  localparam int W  = 32;
  localparam int MC = 5;
  localparam int DC = 10;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         cancel;
  logic         chk_en;
  logic [2:0]   op;
  logic [W-1:0] rs_data;
  logic [W-1:0] rt_data;
  logic         busy;
  logic         stall;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           cycles;
  } exp_t;

  exp_t exp_q[$];

  logic [W-1:0] m_hi = 32'h0;
  logic [W-1:0] m_lo = 32'h0;

  always #5 clk = ~clk;

  mdu_pipe #(
    .WIDTH(W),
    .MULT_CYCLES(MC),
    .DIV_CYCLES(DC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .op(op),
    .rs_data(rs_data),
    .rt_data(rt_data),
    .cancel(cancel),
    .busy(busy),
    .stall(stall),
    .hi(hi),
    .lo(lo)
  );

  mdu_pipe_chk chk (
    .clk(clk),
    .reset(reset),
    .en(chk_en),
    .start(start),
    .busy(busy)
  );

  task automatic chk_w(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic chk_b(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, act, req);
    end
  endtask

  function automatic bit is_long(input logic [2:0] o);
`ifdef MDU_MADD_EN
    return (o <= 3'd3) || (o >= 3'd6);
`else
    return (o <= 3'd3);
`endif
  endfunction

  function automatic int op_cycles(input logic [2:0] o);
    return (o == 3'd2 || o == 3'd3) ? DC : MC;
  endfunction

  // Reference result {hi,lo} of a long op from plain integer arithmetic.
  function automatic logic [63:0] model_result(input logic [2:0] o, input logic [W-1:0] a,
                                               input logic [W-1:0] b, input logic [W-1:0] oh,
                                               input logic [W-1:0] ol);
    int x;
    int y;
    longint p;
    x = $signed(a);
    y = $signed(b);
    p = longint'(x) * longint'(y);
    case (o)
      3'd0: return p;
      3'd1: return {32'd0, a} * {32'd0, b};
      3'd2: begin
        if (b == 32'd0) return {oh, ol};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        return {x % y, x / y};
      end
      3'd3: begin
        if (b == 32'd0) return {oh, ol};
        return {a % b, a / b};
      end
      3'd6: return {oh, ol} + p;
      3'd7: return {oh, ol} - p;
      default: return {oh, ol};
    endcase
  endfunction

  // Issue one op; cancel_at > 0 aborts in that busy cycle; inject adds an
  // illegal start in busy cycle 2 that the unit must ignore.
  task automatic do_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input int cancel_at, input bit inject);
    logic [63:0] r;
    int n;
    exp_t e;
    @(negedge clk);
    start = 1'b1; op = o; rs_data = a; rt_data = b; cancel = 1'b0;
    #1 chk_b("stall_issue", stall, is_long(o));
    n = op_cycles(o);
    if (is_long(o)) begin
      if (cancel_at > 0) begin
        e = '{m_hi, m_lo, cancel_at};
      end else begin
        r = model_result(o, a, b, m_hi, m_lo);
        m_hi = r[63:32];
        m_lo = r[31:0];
        e = '{m_hi, m_lo, n};
      end
      exp_q.push_back(e);
    end else if (o == 3'd4) begin
      if (a != m_hi) begin
        m_hi = a;
        exp_q.push_back('{m_hi, m_lo, 0});
      end
    end else if (o == 3'd5) begin
      if (a != m_lo) begin
        m_lo = a;
        exp_q.push_back('{m_hi, m_lo, 0});
      end
    end
    @(negedge clk);
    start = 1'b0;
    if (is_long(o)) begin
      for (int c = 1; c <= n; c++) begin
        cancel = (c == cancel_at);
        if (inject && c == 2) begin
          chk_en = 1'b0; start = 1'b1; op = 3'd0;
          rs_data = $urandom; rt_data = $urandom;
        end
        #1 chk_b("stall_busy", stall, 1'b1);
        @(negedge clk);
        start = 1'b0; chk_en = 1'b1; cancel = 1'b0;
        if (c == cancel_at) break;
      end
    end
    repeat (2) @(negedge clk);
  endtask

  // Start with cancel in the same cycle: must be dropped entirely.
  task automatic start_cancel(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start = 1'b1; cancel = 1'b1; op = o; rs_data = a; rt_data = b;
    #1 chk_b("stall_cancel", stall, 1'b0);
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    @(negedge clk);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return W'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: pop and compare on each completed op or idle HI/LO update.
  initial begin : monitor
    logic         busy_q;
    logic [W-1:0] hi_q;
    logic [W-1:0] lo_q;
    int           bcnt;
    exp_t         e;
    busy_q = 1'b0; hi_q = 32'h0; lo_q = 32'h0; bcnt = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        busy_q = 1'b0; bcnt = 0; hi_q = hi; lo_q = lo;
      end else begin
        if ((busy_q && !busy) || (!busy && (hi !== hi_q || lo !== lo_q))) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: hi=%h lo=%h with no op pending", hi, lo);
          end else begin
            e = exp_q.pop_front();
            chk_w("hi", hi, e.hi);
            chk_w("lo", lo, e.lo);
            chk_w("busy_cycles", W'(bcnt), W'(e.cycles));
          end
          bcnt = 0;
        end
        if (busy) bcnt++;
        busy_q = busy; hi_q = hi; lo_q = lo;
      end
    end
  end

  // Driver: reset, directed cases, mid-run reset, then randomized ops.
  initial begin : driver
    logic [2:0] ro;
    int         ca;
    reset = 1'b1; start = 1'b0; cancel = 1'b0; chk_en = 1'b1;
    op = 3'd0; rs_data = 32'h0; rt_data = 32'h0;
    repeat (3) @(negedge clk);
    chk_b("reset_busy", busy, 1'b0);
    chk_b("reset_stall", stall, 1'b0);
    chk_w("reset_hi", hi, 32'h0);
    chk_w("reset_lo", lo, 32'h0);
    reset = 1'b0;

    do_op(3'd0, 32'hFFFF_FFFF, 32'd2, 0, 1'b0);           // MULT -1*2
    do_op(3'd1, 32'hFFFF_FFFF, 32'd2, 0, 1'b0);           // MULTU
    do_op(3'd2, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);           // DIV -7/2
    do_op(3'd4, 32'h11, 32'd0, 0, 1'b0);                  // MTHI
    do_op(3'd5, 32'h22, 32'd0, 0, 1'b0);                  // MTLO
    do_op(3'd3, 32'd7, 32'd0, 0, 1'b0);                   // DIVU by zero
    do_op(3'd4, 32'hABCD_0000, 32'd0, 0, 1'b0);           // MTHI
    do_op(3'd0, 32'd3, 32'd5, 0, 1'b1);                   // MULT with start while busy
    do_op(3'd2, 32'd100, 32'd7, 4, 1'b0);                 // DIV cancelled in 4th busy cycle
    start_cancel(3'd5, 32'h999, 32'd0);
    start_cancel(3'd0, 32'd9, 32'd9);
    do_op(3'd3, 32'd1, 32'd0, 0, 1'b0);                   // probe: nothing changed
    do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);   // signed overflow
    do_op(3'd2, 32'd7, 32'hFFFF_FFFE, 0, 1'b0);           // 7 / -2
`ifdef MDU_MADD_EN
    do_op(3'd1, 32'd0, 32'd0, 0, 1'b0);
    do_op(3'd5, 32'd10, 32'd0, 0, 1'b0);
    do_op(3'd6, 32'd3, 32'd4, 0, 1'b0);                   // MADD -> lo 22
    do_op(3'd7, 32'd1, 32'd23, 0, 1'b0);                  // MSUB -> all ones
`else
    do_op(3'd6, 32'd3, 32'd4, 0, 1'b0);                   // reserved, ignored
    do_op(3'd7, 32'd1, 32'd23, 0, 1'b0);
`endif

    // Reset in the middle of a MULT.
    @(negedge clk);
    start = 1'b1; op = 3'd0; rs_data = 32'd6; rt_data = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1 chk_b("midrun_reset_busy", busy, 1'b0);
    chk_w("midrun_reset_hi", hi, 32'h0);
    chk_w("midrun_reset_lo", lo, 32'h0);
    m_hi = 32'h0; m_lo = 32'h0;
    @(negedge clk);
    #2 reset = 1'b0;

    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 7));
      ca = 0;
      if ($urandom_range(0, 9) == 0) begin
        start_cancel(ro, pick(), pick());
      end else begin
        if (is_long(ro) && $urandom_range(0, 7) == 0) ca = $urandom_range(1, op_cycles(ro));
        do_op(ro, pick(), pick(), ca, is_long(ro) && ($urandom_range(0, 9) == 0));
      end
    end

    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations outstanding, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu_pipe.md
Name: mdu_pipe

Overview:
- Parametrised multiply/divide unit with HI/LO result registers, sitting beside the EX-stage ALU of the 5-stage core.
- Replaces the inline fixed-latency mult/div logic and busy counter.
- Adds configurable width and latencies, a cancel input for the upcoming exception work, and a defined divide-by-zero result.
- The decode/hazard stage stalls MDU-class instructions on the `stall` output.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- MULT_CYCLES, 5, busy cycles after a mult/multu issue (≥1).
- DIV_CYCLES, 10, busy cycles after a div/divu issue (≥1).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  issue strobe from EX stage; qualifies op.
- op  in  3  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 reserved (MADD/MSUB when enabled).
- rs_data  in  WIDTH  forwarded rs operand.
- rt_data  in  WIDTH  forwarded rt operand.
- cancel  in  1  abort in-flight op and any same-cycle start.
- busy  out  1  registered; high while an op is in flight.
- stall  out  1  combinational: start & ~cancel & op is MULT..DIVU, OR busy.
- hi  out  WIDTH  HI register (mfhi source).
- lo  out  WIDTH  LO register (mflo source).

Behaviour:
- Reset (async): busy=0, counter=0, hi=0, lo=0, pending result=0, saved op=0.
- States: IDLE, RUN.
- IDLE, start & ~cancel & op in {MULT,MULTU,DIV,DIVU}:
  - compute the 2*WIDTH result from rs_data/rt_data into a pending register;
  - load counter with MULT_CYCLES or DIV_CYCLES;
  - set busy on the next edge and go to RUN.
- IDLE, start & op in {MTHI,MTLO}: write rs_data to hi/lo on the next edge; busy stays 0; no RUN.
- RUN: counter decrements each cycle. On the edge where counter==1, commit pending to hi/lo, clear busy, return to IDLE.
- Commit timing:
  - Issue at edge t → busy=1 on cycles t+1 .. t+N; hi/lo take the new value and busy=0 at edge t+N.
  - hi/lo hold their old values throughout RUN.
- Results:
  - MULT: signed product; hi=upper WIDTH bits, lo=lower.
  - MULTU: unsigned product, same split.
  - DIV: lo=quotient truncated toward zero, hi=remainder with the dividend's sign.
  - DIVU: unsigned quotient and remainder.
  - Divide by zero (rt_data==0): op runs full DIV_CYCLES, then hi/lo are left unchanged.
  - Signed overflow (MIN / -1): lo=MIN, hi=0.
- start while busy: ignored, with no effect on state. This is a protocol violation; assertion in simulation.
- Reserved op codes (without the macro): ignored.
- cancel in RUN: return to IDLE next edge, busy=0, hi/lo keep pre-op values.
- cancel in IDLE with start: start dropped, including MTHI/MTLO.
- cancel in IDLE without start: no effect.
- reset mid-RUN: immediate return to reset state.

Optional Feature:
- Macro MDU_MADD_EN.
- Defined: op 6 = MADD, op 7 = MSUB, both signed and using MULT_CYCLES. At commit, {hi,lo} = {hi,lo} ± product, with hi/lo sampled at commit time. A MTHI/MTLO is blocked by stall while busy, so no race.
- Undefined: ops 6/7 ignored like any reserved code; no accumulator adder is synthesised.

Decomposition:
- Shared package mdu_pkg:
  - op-code localparams MDU_MULT..MDU_MSUB;
  - state typedef (IDLE, RUN);
  - helper function is_mdu_long(op) for hazard logic reuse.
- One natural sub-module: mdu_divider, a combinational signed/unsigned quotient/remainder with the zero and overflow rules, shared with future iterative versions.

Test Plan:
- reset; MULT rs=0xFFFFFFFF(-1), rt=2 → busy=1 for 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFE, busy=0.
- MULTU rs=0xFFFFFFFF, rt=2 → hi=0x00000001, lo=0xFFFFFFFE after 5 cycles.
- DIV rs=-7, rt=2 → after 10 cycles lo=0xFFFFFFFD(-3), hi=0xFFFFFFFF(-1); DIVU rs=7, rt=0 with prior hi=0x11, lo=0x22 → unchanged after 10 cycles.
- MTHI rs=0xABCD0000 → hi updated next edge, busy never asserts; then start MULT while busy → second start ignored, first result intact.
- DIV issued, cancel on the 4th busy cycle → busy=0 next edge, hi/lo equal pre-issue values; start+cancel same cycle → no state change.
- With MDU_MADD_EN: hi=0, lo=10, MADD rs=3, rt=4 → lo=22 after 5 cycles; MSUB rs=1, rt=23 → {hi,lo}=-1 (0xFFFFFFFF, 0xFFFFFFFF).
